// File: rtl/nvdla_csb_reg_master_pkg.sv
// ---------------------------------------------------------------------------
// nvdla_csb_reg_master_pkg
// Shared definitions for the CSB register master.
//   - Bit positions of the fields inside the 63-bit CSB request packet.
//   - Bit positions of the fields inside the 34-bit CSB response packet.
//   - Response type codes.
//   - FSM state encoding.
//   - A helper that packs a response word.
// There are no ports; this package is imported by the interface and the top.
// ---------------------------------------------------------------------------
package nvdla_csb_reg_master_pkg;

  // Packet widths
  localparam int REQ_PD_W  = 63;
  localparam int RESP_PD_W = 34;

  // Request packet fields
  localparam int ADDR_LSB    = 0;
  localparam int ADDR_MSB    = 21;
  localparam int UNIT_LSB    = 10;
  localparam int WDAT_LSB    = 22;
  localparam int WDAT_MSB    = 53;
  localparam int WRITE_BIT   = 54;
  localparam int NPOSTED_BIT = 55;
  localparam int SRCPRIV_BIT = 56;
  localparam int WRBE_LSB    = 57;
  localparam int WRBE_MSB    = 61;
  localparam int LEVEL_BIT   = 62;

  // Response packet fields
  localparam int RESP_RDAT_LSB = 0;
  localparam int RESP_RDAT_MSB = 31;
  localparam int RESP_ERR_BIT  = 32;
  localparam int RESP_TYPE_BIT = 33;

  localparam logic RESP_TYPE_READ  = 1'b0;
  localparam logic RESP_TYPE_WRITE = 1'b1;

  // Transaction FSM: one request takes exactly three cycles
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Builds a response word as {type, error, rdat}
  function automatic logic [RESP_PD_W-1:0] packResp(input logic respType,
                                                    input logic respErr,
                                                    input logic [31:0] respRdat);
    logic [RESP_PD_W-1:0] word;
    word = '0;
    word[RESP_TYPE_BIT] = respType;
    word[RESP_ERR_BIT] = respErr;
    word[RESP_RDAT_MSB:RESP_RDAT_LSB] = respRdat;
    return word;
  endfunction

endpackage

// File: rtl/nvdla_csb_reg_master_if.sv
// ---------------------------------------------------------------------------
// nvdla_csb_reg_master_if
// Bundles the CSB request/response handshake and the flat register-file
// interface seen by the CSB register master.
//   csb2reg_req_pvld / prdy / pd : request handshake (ring stop -> master)
//   reg2csb_resp_valid / pd      : response pulse   (master -> ring stop)
//   reg_offset / reg_wr_en / reg_wr_data : register access (master -> regfile)
//   reg_rd_data                  : combinational read data (regfile -> master)
// Modports:
//   master : view of nvdla_csb_reg_master
//   slave  : view of the ring stop and register file around it
// ---------------------------------------------------------------------------
interface nvdla_csb_reg_master_if
  import nvdla_csb_reg_master_pkg::*;
#(
  parameter int OFFSET_W = 12
);

  logic                 csb2reg_req_pvld;
  logic                 csb2reg_req_prdy;
  logic [REQ_PD_W-1:0]  csb2reg_req_pd;
  logic                 reg2csb_resp_valid;
  logic [RESP_PD_W-1:0] reg2csb_resp_pd;
  logic [OFFSET_W-1:0]  reg_offset;
  logic                 reg_wr_en;
  logic [31:0]          reg_wr_data;
  logic [31:0]          reg_rd_data;

  modport master (
    input  csb2reg_req_pvld,
    input  csb2reg_req_pd,
    input  reg_rd_data,
    output csb2reg_req_prdy,
    output reg2csb_resp_valid,
    output reg2csb_resp_pd,
    output reg_offset,
    output reg_wr_en,
    output reg_wr_data
  );

  modport slave (
    output csb2reg_req_pvld,
    output csb2reg_req_pd,
    output reg_rd_data,
    input  csb2reg_req_prdy,
    input  reg2csb_resp_valid,
    input  reg2csb_resp_pd,
    input  reg_offset,
    input  reg_wr_en,
    input  reg_wr_data
  );

endinterface

// File: rtl/nvdla_csb_reg_master.sv
// ---------------------------------------------------------------------------
// nvdla_csb_reg_master
// CSB-side initiator for one unit's register file. Accepts a CSB request,
// checks the unit select, performs one register access and returns a read
// response or a non-posted write acknowledge. One request every 3 cycles.
// Ports:
//   nvdla_core_clk  : core clock
//   nvdla_core_rstn : asynchronous active-low reset
//   bus             : nvdla_csb_reg_master_if.master (CSB + register signals)
// Parameters:
//   UNIT_SEL : value of request address [21:10] that selects this unit
//   OFFSET_W : width of reg_offset
// ---------------------------------------------------------------------------
module nvdla_csb_reg_master
  import nvdla_csb_reg_master_pkg::*;
#(
  parameter logic [11:0] UNIT_SEL = 12'h006,
  parameter int          OFFSET_W = 12
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rstn,
  nvdla_csb_reg_master_if.master         bus
);

  state_e                r_state;
  logic                  r_write;
  logic                  r_nposted;
  logic                  r_hit;
  logic [OFFSET_W-1:0]   r_reg_offset;
  logic                  r_reg_wr_en;
  logic [31:0]           r_reg_wr_data;
  logic                  r_resp_valid;
  logic [RESP_PD_W-1:0]  r_resp_pd;

  logic                  w_req_accept;
  logic                  w_req_hit;
  logic                  w_req_write;
  logic                  w_req_nposted;
  logic [9:0]            w_req_word;
  logic [31:0]           w_req_wdat;
  logic                  w_unused_fields;

  // Request field decode. Byte enables, source privilege and level are not
  // used: every access writes the full 32-bit word.
  assign w_req_word      = bus.csb2reg_req_pd[UNIT_LSB-1:ADDR_LSB];
  assign w_req_hit       = (bus.csb2reg_req_pd[ADDR_MSB:UNIT_LSB] == UNIT_SEL);
  assign w_req_wdat      = bus.csb2reg_req_pd[WDAT_MSB:WDAT_LSB];
  assign w_req_write     = bus.csb2reg_req_pd[WRITE_BIT];
  assign w_req_nposted   = bus.csb2reg_req_pd[NPOSTED_BIT];
  assign w_unused_fields = ^{bus.csb2reg_req_pd[LEVEL_BIT],
                             bus.csb2reg_req_pd[WRBE_MSB:WRBE_LSB],
                             bus.csb2reg_req_pd[SRCPRIV_BIT]};

  // Ready is the only output decoded straight from state, so a new request
  // is taken only while idle.
  assign bus.csb2reg_req_prdy = (r_state == IDLE);
  assign w_req_accept         = bus.csb2reg_req_pvld & bus.csb2reg_req_prdy;

  // Transaction FSM with registered outputs.
  // The register-side outputs are loaded on the accepting edge so they are
  // stable for the whole ACCESS cycle; the register file answers
  // combinationally and the read data is sampled at the end of ACCESS,
  // which puts the response on the bus during RESP. An asynchronous reset
  // clears the write strobe and any pending response at once.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state       <= IDLE;
      r_write       <= 1'b0;
      r_nposted     <= 1'b0;
      r_hit         <= 1'b0;
      r_reg_offset  <= '0;
      r_reg_wr_en   <= 1'b0;
      r_reg_wr_data <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_pd     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_valid <= 1'b0;
          if (w_req_accept) begin
            r_write       <= w_req_write;
            r_nposted     <= w_req_nposted;
            r_hit         <= w_req_hit;
            r_reg_offset  <= OFFSET_W'({w_req_word, 2'b00});
            r_reg_wr_data <= w_req_wdat;
            r_reg_wr_en   <= w_req_write & w_req_hit;
            r_state       <= ACCESS;
          end
        end
        ACCESS: begin
          r_reg_wr_en <= 1'b0;
          if (!r_write) begin
            r_resp_valid <= 1'b1;
            r_resp_pd    <= packResp(RESP_TYPE_READ, ~r_hit,
                                     r_hit ? bus.reg_rd_data : 32'h0);
          end else if (r_nposted) begin
            r_resp_valid <= 1'b1;
            r_resp_pd    <= packResp(RESP_TYPE_WRITE, ~r_hit, 32'h0);
          end else begin
            r_resp_valid <= 1'b0;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_reg_wr_en  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.reg_offset         = r_reg_offset;
  assign bus.reg_wr_en          = r_reg_wr_en;
  assign bus.reg_wr_data        = r_reg_wr_data;
  assign bus.reg2csb_resp_valid = r_resp_valid;
  assign bus.reg2csb_resp_pd    = r_resp_pd;

endmodule

// File: tb/tb_nvdla_csb_reg_master.sv
// ---------------------------------------------------------------------------
// tb_nvdla_csb_reg_master
// Directed bench for nvdla_csb_reg_master. Requests are issued in one linear
// initial block; expected responses are queued when a request is driven and
// popped by a monitor whenever the DUT raises reg2csb_resp_valid.
// ---------------------------------------------------------------------------
module tb_nvdla_csb_reg_master;

  logic clk;
  logic rstn;
  int   testsRun;
  int   testsFailed;
  logic [33:0] expQ[$];

  nvdla_csb_reg_master_if #(.OFFSET_W(12)) bus ();

  nvdla_csb_reg_master #(
    .UNIT_SEL (12'h006),
    .OFFSET_W (12)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus.master)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file stand-in: every word reads back a known pattern
  function automatic logic [31:0] rdModel(input logic [11:0] off);
    return 32'h0001_0000 | {22'h0, off[11:2]};
  endfunction

  assign bus.reg_rd_data = rdModel(bus.reg_offset);

  // Expected response for a request: {type, error, rdat}
  function automatic logic [33:0] expResp(input logic [21:0] addr,
                                          input logic write);
    logic hit;
    hit = (addr[21:10] == 12'h006);
    if (write)
      return {1'b1, ~hit, 32'h0};
    return {1'b0, ~hit, (hit ? rdModel({addr[9:0], 2'b00}) : 32'h0)};
  endfunction

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one request starting at a negedge and checks the three-cycle
  // transaction. With hold=1, pvld stays high so the next call overlaps.
  task automatic applyStimulus(input logic [21:0] addr, input logic [31:0] wdat,
                               input logic write, input logic nposted,
                               input logic hold);
    logic hit;
    logic respExp;
    int   waitCycles;
    hit     = (addr[21:10] == 12'h006);
    respExp = !write || nposted;
    // level/wrbe/srcpriv set to nonzero junk that must be ignored
    bus.csb2reg_req_pd   = {1'b1, 5'b00110, 1'b1, nposted, write, wdat, addr};
    bus.csb2reg_req_pvld = 1'b1;
    waitCycles = 0;
    while (!bus.csb2reg_req_prdy && waitCycles < 8) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.csb2reg_req_prdy) begin
      checkOutput("accept_timeout", 64'(bus.csb2reg_req_prdy), 64'd1);
      bus.csb2reg_req_pvld = 1'b0;
      return;
    end
    if (respExp) expQ.push_back(expResp(addr, write));
    @(posedge clk);
    @(negedge clk);
    checkOutput("prdy_T1", 64'(bus.csb2reg_req_prdy), 64'd0);
    checkOutput("offset_T1", 64'(bus.reg_offset), 64'({addr[9:0], 2'b00}));
    checkOutput("wrdata_T1", 64'(bus.reg_wr_data), 64'(wdat));
    checkOutput("wren_T1", 64'(bus.reg_wr_en), 64'(write & hit));
    checkOutput("rvalid_T1", 64'(bus.reg2csb_resp_valid), 64'd0);
    if (!hold) bus.csb2reg_req_pvld = 1'b0;
    @(negedge clk);
    checkOutput("prdy_T2", 64'(bus.csb2reg_req_prdy), 64'd0);
    checkOutput("wren_T2", 64'(bus.reg_wr_en), 64'd0);
    checkOutput("rvalid_T2", 64'(bus.reg2csb_resp_valid), 64'(respExp));
    @(negedge clk);
    checkOutput("prdy_T3", 64'(bus.csb2reg_req_prdy), 64'd1);
    checkOutput("rvalid_T3", 64'(bus.reg2csb_resp_valid), 64'd0);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    if (rstn && bus.reg2csb_resp_valid) begin
      if (expQ.size() == 0)
        checkOutput("unexpected_resp", 64'(bus.reg2csb_resp_valid), 64'd0);
      else
        checkOutput("resp_pd", 64'(bus.reg2csb_resp_pd), 64'(expQ.pop_front()));
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rstn        = 1'b0;
    bus.csb2reg_req_pvld = 1'b0;
    bus.csb2reg_req_pd   = '0;
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_prdy", 64'(bus.csb2reg_req_prdy), 64'd1);
    checkOutput("rst_rvalid", 64'(bus.reg2csb_resp_valid), 64'd0);
    checkOutput("rst_rpd", 64'(bus.reg2csb_resp_pd), 64'd0);
    checkOutput("rst_wren", 64'(bus.reg_wr_en), 64'd0);
    checkOutput("rst_offset", 64'(bus.reg_offset), 64'd0);
    checkOutput("rst_wrdata", 64'(bus.reg_wr_data), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Idle with pvld low: nothing captured
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_prdy", 64'(bus.csb2reg_req_prdy), 64'd1);
      checkOutput("idle_wren", 64'(bus.reg_wr_en), 64'd0);
    end

    // Read hit, non-posted write hit, posted write hit
    applyStimulus(22'h001801, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(22'h001801, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    applyStimulus(22'h001801, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // Misses: read, non-posted write, posted write
    applyStimulus(22'h001C00, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    applyStimulus(22'h001C00, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    applyStimulus(22'h001C00, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);

    // Back-to-back reads with pvld held high
    applyStimulus(22'h001803, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(22'h0018FF, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(22'h0019AA, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset during ACCESS of a non-posted write
    @(negedge clk);
    bus.csb2reg_req_pd   = {7'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 22'h001805};
    bus.csb2reg_req_pvld = 1'b1;
    @(posedge clk);
    #1;
    bus.csb2reg_req_pvld = 1'b0;
    checkOutput("wren_pre_reset", 64'(bus.reg_wr_en), 64'd1);
    rstn = 1'b0;
    #1;
    checkOutput("wren_in_reset", 64'(bus.reg_wr_en), 64'd0);
    checkOutput("prdy_in_reset", 64'(bus.csb2reg_req_prdy), 64'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_reset_rvalid", 64'(bus.reg2csb_resp_valid), 64'd0);
      checkOutput("post_reset_wren", 64'(bus.reg_wr_en), 64'd0);
    end

    // First request after reset served normally
    applyStimulus(22'h001802, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
